// File: rtl/time_adjust_ctrl.sv
// Front-panel adjust sequencer: mode/up/down buttons -> adjust flag,
// one-hot field select, inc/dec strobes, hold-repeat, idle timeout.
// Ports: clk_1Hz, rst_n (async low); mode_btn, up_btn, down_btn (raw);
// adjust, field_sel[5:0], inc_pulse[5:0], dec_pulse[5:0], blink.
module time_adjust_ctrl #(
  parameter int REPEAT_DELAY = 2,
  parameter int IDLE_TIMEOUT = 30
) (
  input  logic       clk_1Hz,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic       adjust,
  output logic [5:0] field_sel,
  output logic [5:0] inc_pulse,
  output logic [5:0] dec_pulse,
  output logic       blink
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_DELAY);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

  localparam logic [2:0] RUN      = 3'd0;
  localparam logic [2:0] ADJ_SEC  = 3'd1;
  localparam logic [2:0] ADJ_MIN  = 3'd2;
  localparam logic [2:0] ADJ_HOUR = 3'd3;
  localparam logic [2:0] ADJ_DAY  = 3'd4;
  localparam logic [2:0] ADJ_MON  = 3'd5;
  localparam logic [2:0] ADJ_YEAR = 3'd6;

  // bit 2 = mode, bit 1 = up, bit 0 = down
  logic [2:0]    s1, s2, p;
  logic [2:0]    state, state_nx;
  logic [RW-1:0] up_rep, dn_rep;
  logic [IW-1:0] idle;

  logic mode_edge, up_edge, dn_edge;
  logic in_adj, both, up_stb, dn_stb;
  logic act, enter, to_run;

  function automatic logic [5:0] sel_of(input logic [2:0] s);
    logic [5:0] r;
    r = 6'b0;
    case (s)
      ADJ_SEC:  r = 6'b000001;
      ADJ_MIN:  r = 6'b000010;
      ADJ_HOUR: r = 6'b000100;
      ADJ_DAY:  r = 6'b001000;
      ADJ_MON:  r = 6'b010000;
      ADJ_YEAR: r = 6'b100000;
      default:  r = 6'b0;
    endcase
    return r;
  endfunction

  assign mode_edge = s2[2] & ~p[2];
  assign up_edge   = s2[1] & ~p[1];
  assign dn_edge   = s2[0] & ~p[0];

  assign in_adj = (state != RUN);
  assign both   = s2[1] & s2[0];

  // A mode edge pre-empts any strobe in the same cycle.
  assign up_stb = in_adj & ~mode_edge & ~both & s2[1] &
                  (up_edge | (up_rep == REP_MAX));
  assign dn_stb = in_adj & ~mode_edge & ~both & s2[0] &
                  (dn_edge | (dn_rep == REP_MAX));

  // Button activity in this cycle keeps the panel alive.
  assign act = up_edge | dn_edge | up_stb | dn_stb;

  always_comb begin
    state_nx = state;
    if (mode_edge) begin
      state_nx = (state == ADJ_YEAR) ? RUN : state + 3'd1;
    end else if (in_adj && idle == IDLE_MAX && !act) begin
      state_nx = RUN;
    end
  end

  assign to_run = (state_nx == RUN);
  assign enter  = (state_nx != state) & ~to_run;

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 3'b0;
      s2        <= 3'b0;
      p         <= 3'b0;
      state     <= RUN;
      adjust    <= 1'b0;
      field_sel <= 6'b0;
      inc_pulse <= 6'b0;
      dec_pulse <= 6'b0;
      blink     <= 1'b0;
      up_rep    <= '0;
      dn_rep    <= '0;
      idle      <= '0;
    end else begin
      s1        <= {mode_btn, up_btn, down_btn};
      s2        <= s1;
      p         <= s2;
      state     <= state_nx;
      adjust    <= ~to_run;
      field_sel <= sel_of(state_nx);
      inc_pulse <= up_stb ? sel_of(state) : 6'b0;
      dec_pulse <= dn_stb ? sel_of(state) : 6'b0;
      blink     <= (to_run | enter) ? 1'b0 : ~blink;

      if (to_run || enter || act)
        idle <= '0;
      else if (idle != IDLE_MAX)
        idle <= idle + 1'b1;

      if (!in_adj || mode_edge || both || !s2[1])
        up_rep <= '0;
      else if (up_rep != REP_MAX)
        up_rep <= up_rep + 1'b1;

      if (!in_adj || mode_edge || both || !s2[0])
        dn_rep <= '0;
      else if (dn_rep != REP_MAX)
        dn_rep <= dn_rep + 1'b1;
    end
  end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl.
// Tasks per scenario; counts checks and errors.
module tb_time_adjust_ctrl;

  logic       clk_1Hz = 1'b0;
  logic       rst_n;
  logic       mode_btn, up_btn, down_btn;
  logic       adjust, blink;
  logic [5:0] field_sel, inc_pulse, dec_pulse;

  int errors = 0;
  int checks = 0;

  time_adjust_ctrl #(
    .REPEAT_DELAY(2),
    .IDLE_TIMEOUT(30)
  ) dut (
    .clk_1Hz  (clk_1Hz),
    .rst_n    (rst_n),
    .mode_btn (mode_btn),
    .up_btn   (up_btn),
    .down_btn (down_btn),
    .adjust   (adjust),
    .field_sel(field_sel),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .blink    (blink)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic step();
    @(posedge clk_1Hz);
    #1;
  endtask

  // one-tick mode press; returns right after the 3rd edge
  task automatic press_mode();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    step();
    step();
  endtask

  task automatic gap();
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode_btn = 1'b0;
    up_btn = 1'b0;
    down_btn = 1'b0;
    #2;
    checks++;
    if ({adjust, field_sel, inc_pulse, dec_pulse, blink} !== 20'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 0",
               {adjust, field_sel, inc_pulse, dec_pulse, blink});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mode_cycle();
    logic [5:0] exp [7];
    logic [5:0] prev;
    exp = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
            6'b010000, 6'b100000, 6'b000000};
    prev = 6'b0;
    for (int i = 0; i < 7; i++) begin
      mode_btn = 1'b1;
      step();
      mode_btn = 1'b0;
      step();
      checks++;
      if (field_sel !== prev) begin
        errors++;
        $display("FAIL mode_early[%0d] got %b want %b", i, field_sel, prev);
      end
      step();
      checks++;
      if (field_sel !== exp[i] || adjust !== (exp[i] != 6'b0)) begin
        errors++;
        $display("FAIL mode_sel[%0d] got %b/%b want %b/%b", i,
                 field_sel, adjust, exp[i], exp[i] != 6'b0);
      end
      if (i == 0) begin
        checks++;
        if (blink !== 1'b0) begin
          errors++;
          $display("FAIL blink_entry got %b want 0", blink);
        end
        step();
        checks++;
        if (blink !== 1'b1) begin
          errors++;
          $display("FAIL blink_toggle got %b want 1", blink);
        end
        step();
      end else begin
        gap();
      end
      prev = exp[i];
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      press_mode();
      gap();
    end
    up_btn = 1'b1;
    step();
    up_btn = 1'b0;
    step();
    checks++;
    if (inc_pulse !== 6'b0) begin
      errors++;
      $display("FAIL up_early got %b want 0", inc_pulse);
    end
    step();
    checks++;
    if (inc_pulse !== 6'b000100 || dec_pulse !== 6'b0) begin
      errors++;
      $display("FAIL up_pulse got %b/%b want 000100/0",
               inc_pulse, dec_pulse);
    end
    step();
    checks++;
    if (inc_pulse !== 6'b0) begin
      errors++;
      $display("FAIL up_one_cycle got %b want 0", inc_pulse);
    end
    gap();
    down_btn = 1'b1;
    step();
    down_btn = 1'b0;
    step();
    step();
    checks++;
    if (dec_pulse !== 6'b000100 || inc_pulse !== 6'b0) begin
      errors++;
      $display("FAIL dn_pulse got %b/%b want 000100/0",
               dec_pulse, inc_pulse);
    end
    step();
    checks++;
    if (dec_pulse !== 6'b0) begin
      errors++;
      $display("FAIL dn_one_cycle got %b want 0", dec_pulse);
    end
    gap();
    for (int i = 0; i < 4; i++) begin
      press_mode();
      gap();
    end
    checks++;
    if (adjust !== 1'b0) begin
      errors++;
      $display("FAIL back_to_run got %b want 0", adjust);
    end
    up_btn = 1'b1;
    step();
    up_btn = 1'b0;
    down_btn = 1'b1;
    step();
    down_btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (inc_pulse !== 6'b0 || dec_pulse !== 6'b0) begin
        errors++;
        $display("FAIL run_ignore[%0d] got %b/%b want 0/0", i,
                 inc_pulse, dec_pulse);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp [12];
    exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    press_mode();
    gap();
    up_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) up_btn = 1'b0;
      step();
      checks++;
      if (inc_pulse !== (exp[i] ? 6'b000001 : 6'b0) ||
          dec_pulse !== 6'b0) begin
        errors++;
        $display("FAIL repeat[E%0d] got %b/%b want %b/0", i + 1,
                 inc_pulse, dec_pulse, exp[i] ? 6'b000001 : 6'b0);
      end
    end
  endtask

  task automatic test_conflict();
    up_btn = 1'b1;
    down_btn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        up_btn = 1'b0;
        down_btn = 1'b0;
      end
      step();
      checks++;
      if (inc_pulse !== 6'b0 || dec_pulse !== 6'b0) begin
        errors++;
        $display("FAIL both_held[%0d] got %b/%b want 0/0", i,
                 inc_pulse, dec_pulse);
      end
    end
    for (int i = 0; i < 3; i++) begin
      press_mode();
      gap();
    end
    mode_btn = 1'b1;
    up_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    up_btn = 1'b0;
    step();
    step();
    checks++;
    if (field_sel !== 6'b010000 || inc_pulse !== 6'b0) begin
      errors++;
      $display("FAIL mode_vs_up got %b/%b want 010000/0",
               field_sel, inc_pulse);
    end
    step();
    checks++;
    if (inc_pulse !== 6'b0) begin
      errors++;
      $display("FAIL mode_vs_up_late got %b want 0", inc_pulse);
    end
    step();
  endtask

  task automatic test_timeout();
    press_mode();
    checks++;
    if (field_sel !== 6'b100000) begin
      errors++;
      $display("FAIL year_entry got %b want 100000", field_sel);
    end
    for (int i = 0; i < 29; i++) step();
    checks++;
    if (adjust !== 1'b1 || field_sel !== 6'b100000) begin
      errors++;
      $display("FAIL to_tick29 got %b/%b want 1/100000",
               adjust, field_sel);
    end
    step();
    checks++;
    if (adjust !== 1'b0 || field_sel !== 6'b0) begin
      errors++;
      $display("FAIL to_tick30 got %b/%b want 0/0", adjust, field_sel);
    end
    gap();
    for (int i = 0; i < 5; i++) begin
      press_mode();
      gap();
    end
    press_mode();
    for (int i = 0; i < 17; i++) step();
    up_btn = 1'b1;
    step();
    up_btn = 1'b0;
    step();
    step();
    checks++;
    if (inc_pulse !== 6'b100000) begin
      errors++;
      $display("FAIL to_up_pulse got %b want 100000", inc_pulse);
    end
    for (int i = 0; i < 29; i++) step();
    checks++;
    if (adjust !== 1'b1) begin
      errors++;
      $display("FAIL to_restart29 got %b want 1", adjust);
    end
    step();
    checks++;
    if (adjust !== 1'b0 || field_sel !== 6'b0) begin
      errors++;
      $display("FAIL to_restart30 got %b/%b want 0/0",
               adjust, field_sel);
    end
    gap();
  endtask

  task automatic test_reset_mid();
    press_mode();
    gap();
    press_mode();
    gap();
    up_btn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({adjust, field_sel, inc_pulse, dec_pulse, blink} !== 20'b0) begin
      errors++;
      $display("FAIL reset_async got %b want 0",
               {adjust, field_sel, inc_pulse, dec_pulse, blink});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (adjust !== 1'b0 || inc_pulse !== 6'b0) begin
        errors++;
        $display("FAIL reset_after[%0d] got %b/%b want 0/0", i,
                 adjust, inc_pulse);
      end
    end
    up_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_single();
    test_repeat();
    test_conflict();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
